// File: rtl/snn_multilayer_engine.sv
// Two-layer threshold/shift spiking network engine with sequential weight fetch.
// Optional SNN_SAT_EN: additions and left shifts saturate instead of wrapping.
module snn_multilayer_engine #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_HID  = 2,
  parameter int unsigned ACC_W  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned W_BASE = 0,
  parameter int unsigned TH1    = 1,
  parameter int unsigned TH2    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*N_IN-1:0]   in_vec,
  output logic                w_req,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic                w_valid,
  input  logic [7:0]          w_data,
  output logic                busy,
  output logic [N_HID-1:0]    hid_spike,
  output logic [ACC_W-1:0]    prediction,
  output logic                out_spike,
  output logic                done
);

  localparam int unsigned NW  = N_HID * (N_IN + 1);
  localparam int unsigned L1N = N_HID * N_IN;
  localparam int unsigned KW  = $clog2(NW + 1);
  localparam int unsigned HW  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [ACC_W-1:0] Th1A = ACC_W'(TH1);
  localparam logic [ACC_W-1:0] Th2A = ACC_W'(TH2);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StMacHi, StMacLo, StDone} state_e;

  state_e state_q, state_d;

  logic [4*N_IN-1:0] x_q, x_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [KW-1:0]     k_q, k_d;
  logic [IW-1:0]     l1_i_q, l1_i_d;
  logic [HW-1:0]     l1_h_q, l1_h_d;
  logic [HW-1:0]     h2_q, h2_d;
  logic [ACC_W-1:0]  hid_sum_q [N_HID];
  logic [ACC_W-1:0]  hid_sum_d [N_HID];
  logic [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic [N_HID-1:0]  hid_spike_q, hid_spike_d;
  logic [ACC_W-1:0]  prediction_q, prediction_d;
  logic              out_spike_q, out_spike_d;
  logic              done_q, done_d;

  // s >= 0 shifts left, s < 0 shifts right logically by -s (s = -8 clears 8-bit operands).
  function automatic logic [ACC_W-1:0] shift_op(input logic [ACC_W-1:0] op,
                                                input logic [3:0] s);
    logic [ACC_W-1:0] res;
    logic [3:0]       mag;
`ifdef SNN_SAT_EN
    logic [ACC_W+7:0] wide;
`endif
    mag = ~s + 4'd1;
    if (!s[3]) begin
`ifdef SNN_SAT_EN
      wide = {8'd0, op} << s[2:0];
      res  = (|wide[ACC_W+7:ACC_W]) ? '1 : wide[ACC_W-1:0];
`else
      res = op << s[2:0];
`endif
    end else begin
      res = op >> mag;
    end
    return res;
  endfunction

  function automatic logic [ACC_W-1:0] add_op(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef SNN_SAT_EN
    return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  logic             k_last;
  logic             is_l1;
  logic [3:0]       nib;
  logic [ACC_W-1:0] x_op;
  logic [ACC_W-1:0] hid_sel;

  assign k_last  = (k_q == KW'(NW - 1));
  assign is_l1   = (k_q < KW'(L1N));
  assign nib     = (state_q == StMacHi) ? wdata_q[7:4] : wdata_q[3:0];
  assign x_op    = ACC_W'(x_q[{l1_i_q, 2'b00} +: 4]);
  assign hid_sel = hid_sum_q[h2_q];

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   state_d = StWait;
      StWait:  if (w_valid) state_d = StMacHi;
      StMacHi: state_d = k_last ? StDone : StMacLo;
      StMacLo: state_d = k_last ? StDone : StReq;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_req  = (state_q == StReq);
    w_addr = '0;
    if (w_req) begin
      w_addr = ADDR_W'(W_BASE) + ADDR_W'(k_q >> 1);
    end
    busy = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    x_d          = x_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    l1_i_d       = l1_i_q;
    l1_h_d       = l1_h_q;
    h2_d         = h2_q;
    hid_sum_d    = hid_sum_q;
    out_acc_d    = out_acc_q;
    hid_spike_d  = hid_spike_q;
    prediction_d = prediction_q;
    out_spike_d  = out_spike_q;
    done_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          x_d       = in_vec;
          k_d       = '0;
          l1_i_d    = '0;
          l1_h_d    = '0;
          h2_d      = '0;
          hid_sum_d = '{default: '0};
          out_acc_d = '0;
        end
      end
      StWait: begin
        if (w_valid) wdata_d = w_data;
      end
      StMacHi, StMacLo: begin
        k_d = k_q + KW'(1);
        if (is_l1) begin
          hid_sum_d[l1_h_q] = add_op(hid_sum_q[l1_h_q], shift_op(x_op, nib));
          if (l1_i_q == IW'(N_IN - 1)) begin
            l1_i_d = '0;
            l1_h_d = l1_h_q + HW'(1);
          end else begin
            l1_i_d = l1_i_q + IW'(1);
          end
        end else begin
          // Only spiking hidden neurons contribute to the output neuron.
          if (hid_sel > Th1A) out_acc_d = add_op(out_acc_q, shift_op(hid_sel, nib));
          h2_d = h2_q + HW'(1);
        end
      end
      StDone: begin
        for (int h = 0; h < int'(N_HID); h++) hid_spike_d[h] = (hid_sum_q[h] > Th1A);
        prediction_d = out_acc_q;
        out_spike_d  = (out_acc_q > Th2A);
        done_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x_q          <= '0;
      wdata_q      <= '0;
      k_q          <= '0;
      l1_i_q       <= '0;
      l1_h_q       <= '0;
      h2_q         <= '0;
      hid_sum_q    <= '{default: '0};
      out_acc_q    <= '0;
      hid_spike_q  <= '0;
      prediction_q <= '0;
      out_spike_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      x_q          <= x_d;
      wdata_q      <= wdata_d;
      k_q          <= k_d;
      l1_i_q       <= l1_i_d;
      l1_h_q       <= l1_h_d;
      h2_q         <= h2_d;
      hid_sum_q    <= hid_sum_d;
      out_acc_q    <= out_acc_d;
      hid_spike_q  <= hid_spike_d;
      prediction_q <= prediction_d;
      out_spike_q  <= out_spike_d;
      done_q       <= done_d;
    end
  end

  assign hid_spike  = hid_spike_q;
  assign prediction = prediction_q;
  assign out_spike  = out_spike_q;
  assign done       = done_q;

endmodule

// File: tb/tb_snn_multilayer_engine.sv
// Self-checking bench for snn_multilayer_engine with a behavioural weight memory and
// an arithmetic reference model of the two-layer network.
module tb_snn_multilayer_engine;

  localparam int N_IN = 4;
  localparam int N_HID = 2;
  localparam int NWORDS = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in_vec;
  logic        w_req;
  logic [3:0]  w_addr;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        busy;
  logic [1:0]  hid_spike;
  logic [7:0]  prediction;
  logic        out_spike;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  int         mem_delay = 0;
  int         req_cnt = 0;
  logic [3:0] req_addrs [$];

  snn_multilayer_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_vec     (in_vec),
    .w_req      (w_req),
    .w_addr     (w_addr),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .busy       (busy),
    .hid_spike  (hid_spike),
    .prediction (prediction),
    .out_spike  (out_spike),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Memory responder: answers each request mem_delay cycles later than a single-cycle memory.
  initial begin : responder
    int         cnt;
    logic [3:0] paddr;
    cnt = 0;
    paddr = '0;
    w_valid = 1'b0;
    w_data = '0;
    forever begin
      @(negedge clk);
      w_valid = 1'b0;
      if (rst_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          w_valid = 1'b1;
          w_data = mem[paddr];
        end
      end else if (w_req) begin
        paddr = w_addr;
        cnt = mem_delay + 1;
      end
      if (w_req) begin
        req_cnt++;
        req_addrs.push_back(w_addr);
      end
    end
  end

  function automatic int lim(input int v);
`ifdef SNN_SAT_EN
    return (v > 255) ? 255 : v;
`else
    return v & 255;
`endif
  endfunction

  function automatic int shf(input int op, input int s);
    if (s >= 0) return lim(op << s);
    return op >> (-s);
  endfunction

  function automatic int weight(input int k);
    logic [7:0] b;
    int n;
    b = mem[k / 2];
    n = (k % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]);
    return (n >= 8) ? n - 16 : n;
  endfunction

  task automatic model(input logic [15:0] iv, output logic [1:0] hs, output logic [7:0] pred,
                       output logic os);
    int hid [N_HID];
    int acc;
    acc = 0;
    for (int h = 0; h < N_HID; h++) begin
      hid[h] = 0;
      for (int i = 0; i < N_IN; i++) begin
        hid[h] = lim(hid[h] + shf(int'((iv >> (4 * i)) & 16'hF), weight(h * N_IN + i)));
      end
      hs[h] = (hid[h] > 1);
      if (hid[h] > 1) acc = lim(acc + shf(hid[h], weight(N_HID * N_IN + h)));
    end
    pred = acc[7:0];
    os = (acc > 1);
  endtask

  // Starts an inference and watches until done plus a few cycles; lat = -1 on timeout.
  task automatic run_inf(input logic [15:0] iv, input int dly, input bit second_start,
                         output int lat, output int ndone);
    mem_delay = dly;
    req_cnt = 0;
    req_addrs.delete();
    lat = -1;
    ndone = 0;
    @(negedge clk);
    in_vec = iv;
    start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        start = 1'b0;
        in_vec = 16'($urandom);
      end
      if (second_start && cyc == 6) start = 1'b1;
      if (second_start && cyc == 7) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
      if (lat >= 0 && cyc >= lat + 4) break;
    end
  endtask

  task automatic set_words(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input logic [7:0] w3, input logic [7:0] w4);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, hid_spike, prediction, out_spike, w_req, w_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b hs=%0b pred=%0d os=%0b req=%0b addr=%0d expected all 0",
               busy, done, hid_spike, prediction, out_spike, w_req, w_addr);
    end
  endtask

  task automatic test_basic();
    int lat, nd;
    set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_inf(16'h4321, 0, 1'b0, lat, nd);
    checks++; if (hid_spike !== 2'b11) begin errors++; $display("FAIL basic_hid: got %b expected 11", hid_spike); end
    checks++; if (prediction !== 8'd20) begin errors++; $display("FAIL basic_pred: got %0d expected 20", prediction); end
    checks++; if (out_spike !== 1'b1) begin errors++; $display("FAIL basic_os: got %0b expected 1", out_spike); end
    checks++; if (lat !== 22) begin errors++; $display("FAIL basic_latency: got %0d expected 22", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
    checks++; if (req_cnt !== NWORDS) begin errors++; $display("FAIL basic_req_count: got %0d expected %0d", req_cnt, NWORDS); end
    for (int i = 0; i < NWORDS; i++) begin
      checks++;
      if (req_addrs.size() <= i || req_addrs[i] !== 4'(i)) begin
        errors++;
        $display("FAIL basic_addr%0d: got %0d expected %0d", i,
                 (req_addrs.size() > i) ? int'(req_addrs[i]) : -1, i);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_l2_gating();
    int lat, nd;
    set_words(8'h00, 8'h00, 8'h88, 8'h88, 8'h10);
    run_inf(16'h4321, 0, 1'b0, lat, nd);
    checks++; if (hid_spike !== 2'b01) begin errors++; $display("FAIL gate_hid: got %b expected 01", hid_spike); end
    checks++; if (prediction !== 8'd20) begin errors++; $display("FAIL gate_pred: got %0d expected 20", prediction); end
    checks++; if (out_spike !== 1'b1) begin errors++; $display("FAIL gate_os: got %0b expected 1", out_spike); end
  endtask

  task automatic test_overflow();
    int lat, nd;
    logic [7:0] exp_pred;
`ifdef SNN_SAT_EN
    exp_pred = 8'd255;
`else
    exp_pred = 8'd224;
`endif
    set_words(8'h22, 8'h22, 8'h22, 8'h22, 8'h00);
    run_inf(16'hFFFF, 0, 1'b0, lat, nd);
    checks++; if (hid_spike !== 2'b11) begin errors++; $display("FAIL ovf_hid: got %b expected 11", hid_spike); end
    checks++; if (prediction !== exp_pred) begin errors++; $display("FAIL ovf_pred: got %0d expected %0d", prediction, exp_pred); end
    checks++; if (out_spike !== 1'b1) begin errors++; $display("FAIL ovf_os: got %0b expected 1", out_spike); end
  endtask

  task automatic test_slow_mem_restart();
    int lat, nd;
    set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_inf(16'h4321, 3, 1'b1, lat, nd);
    checks++; if (hid_spike !== 2'b11) begin errors++; $display("FAIL slow_hid: got %b expected 11", hid_spike); end
    checks++; if (prediction !== 8'd20) begin errors++; $display("FAIL slow_pred: got %0d expected 20", prediction); end
    checks++; if (lat !== 37) begin errors++; $display("FAIL slow_latency: got %0d expected 37", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL slow_done_count: got %0d expected 1", nd); end
    checks++; if (req_cnt !== NWORDS) begin errors++; $display("FAIL slow_req_count: got %0d expected %0d", req_cnt, NWORDS); end
  endtask

  task automatic test_mid_reset();
    int lat, nd, spurious;
    set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    mem_delay = 0;
    @(negedge clk);
    in_vec = 16'h4321;
    start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({busy, done, hid_spike, prediction, out_spike} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%0b done=%0b hs=%b pred=%0d os=%0b expected all 0",
               busy, done, hid_spike, prediction, out_spike);
    end
    @(negedge clk);
    rst_n = 1'b0;
    spurious = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (done || busy) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", spurious); end
    run_inf(16'h4321, 0, 1'b0, lat, nd);
    checks++; if (hid_spike !== 2'b11) begin errors++; $display("FAIL midrst_rerun_hid: got %b expected 11", hid_spike); end
    checks++; if (prediction !== 8'd20) begin errors++; $display("FAIL midrst_rerun_pred: got %0d expected 20", prediction); end
    checks++; if (lat !== 22) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 22", lat); end
  endtask

  task automatic test_zero_input();
    int lat, nd;
    set_words(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_inf(16'h0000, 0, 1'b0, lat, nd);
    checks++;
    if ({hid_spike, prediction, out_spike} !== '0) begin
      errors++;
      $display("FAIL zero_outputs: got hs=%b pred=%0d os=%0b expected 0", hid_spike, prediction, out_spike);
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_random();
    int lat, nd;
    logic [15:0] iv;
    logic [1:0]  ehs;
    logic [7:0]  epred;
    logic        eos;
    for (int t = 0; t < 8; t++) begin
      set_words(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      iv = 16'($urandom);
      model(iv, ehs, epred, eos);
      run_inf(iv, int'($urandom_range(0, 2)), 1'b0, lat, nd);
      checks++;
      if ({hid_spike, prediction, out_spike} !== {ehs, epred, eos}) begin
        errors++;
        $display("FAIL rand%0d: in=%h got hs=%b pred=%0d os=%0b expected hs=%b pred=%0d os=%0b",
                 t, iv, hid_spike, prediction, out_spike, ehs, epred, eos);
      end
      checks++; if (nd !== 1) begin errors++; $display("FAIL rand%0d_done: got %0d expected 1", t, nd); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b1;
    start = 1'b0;
    in_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    test_basic();
    test_l2_gating();
    test_overflow();
    test_slow_mem_restart();
    test_mid_reset();
    test_zero_input();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_multilayer_engine.md
Name: snn_multilayer_engine

Overview:
- Parametrised successor of the two-layer threshold/shift network engine.
- N_IN 4-bit input nibbles feed N_HID hidden neurons through per-synapse signed shift weights. A hidden neuron spikes when its sum exceeds TH1.
- One output neuron combines the sums of the spiking hidden neurons through signed shift weights, then compares against TH2.
- Weights are fetched sequentially from shared memory over the existing w_req/w_addr/w_valid/w_data channel owned by the top level.

Parameters:
- N_IN, 4, number of 4-bit input nibbles
- N_HID, 2, number of hidden neurons
- ACC_W, 8, accumulator and prediction width (unsigned)
- ADDR_W, 4, weight address width
- W_BASE, 0, word address of weight nibble 0
- TH1, 1, hidden spike threshold (strict greater-than)
- TH2, 1, output spike threshold (strict greater-than)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset: asynchronous, active-high (asserted when 1)
- start  in  1  one-cycle start pulse; sampled only in IDLE
- in_vec  in  4*N_IN  input nibbles; x_i = in_vec[4i+3:4i]
- w_req  out  1  one-cycle weight read request
- w_addr  out  ADDR_W  word address of the request; 0 when w_req=0
- w_valid  in  1  w_data valid; honoured only in WAIT
- w_data  in  8  two packed 4-bit signed shift weights
- busy  out  1  high in every state except IDLE
- hid_spike  out  N_HID  registered hidden spike vector of the last inference
- prediction  out  ACC_W  registered output sum
- out_spike  out  1  registered (prediction > TH2)
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs and internal registers go to 0, state IDLE. Reset mid-inference aborts the inference; no done pulse is produced.
- Weight ordering (nibble index k):
  - k = h*N_IN+i is the layer-1 weight from x_i to hidden h.
  - k = N_HID*N_IN+h is the layer-2 weight for hidden h.
  - NW = N_HID*(N_IN+1) nibbles; NWORDS = ceil(NW/2).
  - Nibble k lives at word W_BASE+(k>>1): bits [7:4] for even k, [3:0] for odd k.
  - If NW is odd, the final low nibble is ignored.
- Shift semantics, s = 4-bit signed:
  - s >= 0: operand << s, truncated to ACC_W.
  - s < 0: logical operand >> -s. s = -8 yields 0 for ACC_W <= 8.
- Layer-1 operands are x_i zero-extended to ACC_W.
- States:
  - IDLE: on start, latch in_vec, clear hid_sum[] and out_acc, go to REQ. start is ignored in all other states.
  - REQ: w_req=1, w_addr=W_BASE+word index, go to WAIT.
  - WAIT: hold until w_valid; latch w_data, go to MAC_HI. w_valid in any other state is ignored. The memory must not return data in the same cycle as the request.
  - MAC_HI / MAC_LO: process the even / odd nibble.
    - Layer-1 weight: hid_sum[h] += shift(x_i, w).
    - Layer-2 weight: if hid_sum[h] > TH1, out_acc += shift(hid_sum[h], w); otherwise no change.
    - After MAC_LO (or after MAC_HI when it holds the last nibble): go to REQ if words remain, else DONE.
  - DONE: register prediction=out_acc, out_spike, and hid_spike[h]=(hid_sum[h]>TH1). Assert done for one cycle, return to IDLE.
- Accumulation wraps modulo 2^ACC_W.
- Latency: with single-cycle memory (w_valid the cycle after w_req), each word takes 4 cycles. done is high 4*NWORDS+2 cycles after the start edge (22 cycles for defaults).
- Outputs hold their values until the next DONE or reset.

Optional Feature:
- Macro SNN_SAT_EN.
- Defined: every addition and left shift saturates at 2^ACC_W-1 instead of wrapping or truncating.
- Undefined: modulo-2^ACC_W wrap and truncation, as stated above.

Test Plan:
- Defaults, in_vec=0x4321, all 5 words 0x00, single-cycle memory -> hid_spike=2'b11, prediction=20, out_spike=1; done exactly 22 cycles after start; w_req pulses exactly 5 times at addrs 0..4.
- in_vec=0x4321, words {0x00,0x00,0x88,0x88,0x10} -> hid1 sum 0 so no spike; hid_spike=2'b01, prediction=20 (10<<1).
- in_vec=0xFFFF, words 0..3=0x22, word 4=0x00 -> each hidden sum 240; prediction=224 without SNN_SAT_EN, 255 with it; out_spike=1.
- Repeat the first scenario with w_valid delayed 3 cycles per request, and a start pulse issued mid-run -> identical results; second start ignored; done pulses once.
- Assert rst_n during word 2 -> outputs 0, busy=0, no done; the following start reproduces the first scenario's results.
- in_vec=0x0000, any weights -> hid_spike=0, prediction=0, out_spike=0, done still pulses once.
